fwd_arb_rr: RTL
===============

FWD_ARB_RR -- requirements
Module: fwd_arb_rr

Interface
REQ-001 SHALL have parameter N, default 4: number of packetfilter_cores, 1..64.
REQ-002 SHALL have parameter PACKMEM_ADDR_WIDTH, default 8: forwarder read address width.
REQ-003 SHALL have parameter PACKMEM_DATA_WIDTH, default 64: read data width.
REQ-004 SHALL have parameter PLEN_WIDTH, default 32: byte length width.
REQ-005 SHALL have parameter TAG_WIDTH, default 6: reorder tag width.
REQ-006 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 SHALL have derived localparam SEL_W = CLOG2(N): width of the selection index.
REQ-008 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-009 SHALL have these forwarder-side ports: addr in PACKMEM_ADDR_WIDTH; rd_en in 1; rd_data out PACKMEM_DATA_WIDTH; rd_reorder_tag out TAG_WIDTH; rd_data_vld out 1; byte_len out PLEN_WIDTH; done in 1 (end of packet); rdy out 1 (a core is available); ack in 1 (forwarder accepts).
REQ-010 SHALL have these core-side ports: fwd_addr out PACKMEM_ADDR_WIDTH; fwd_rd_en out N; fwd_rd_data in N*PACKMEM_DATA_WIDTH; fwd_rd_reorder_tag in N*TAG_WIDTH; fwd_rd_data_vld in N; fwd_byte_len in N*PLEN_WIDTH; fwd_done out N; rdy_for_fwd in N; rdy_for_fwd_ack out N.
REQ-011 SHALL have these status ports: busy out 1 (session active); cur_sel out SEL_W (index of the locked core).

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 SHALL compute the combinational grant index g in IDLE from rdy_for_fwd: ARB_MODE=0 gives the lowest set bit; ARB_MODE=1 gives the first set bit at or after ptr, wrapping at N-1 -> 0.
REQ-014 SHALL drive rdy = (state==IDLE) && |rdy_for_fwd.
REQ-015 SHALL drive rdy_for_fwd_ack as one-hot at bit g only when rdy && ack, and zero otherwise.
REQ-016 SHALL, on rdy && ack, register cur_sel <= g and set ptr <= (g+1) mod N (RR mode only), then go IDLE -> BUSY.
REQ-017 SHALL, in BUSY, drive fwd_rd_en[cur_sel] = rd_en and all other bits 0.
REQ-018 SHALL, in BUSY, drive fwd_done[cur_sel] = done and all other bits 0.
REQ-019 SHALL, in BUSY with done=1, return to IDLE on the next edge.
REQ-020 SHALL, in BUSY, hold rdy low regardless of rdy_for_fwd; rdy may rise no earlier than the cycle after done.
REQ-021 SHALL ignore done and rd_en in IDLE: fwd_done = 0 and fwd_rd_en = 0.
REQ-022 SHALL ignore ack when rdy=0: no state change and no ack pulse.
REQ-023 SHALL recompute g and rdy combinationally every cycle if rdy_for_fwd changes before ack; no grant is latched without a handshake.
REQ-024 SHALL drive fwd_addr = addr combinationally at all times.
REQ-025 SHALL register the return path: rd_data, rd_reorder_tag, byte_len <= the fields of core cur_sel each cycle.
REQ-026 SHALL register rd_data_vld <= fwd_rd_data_vld[cur_sel] && busy; return latency is exactly 1 cycle after the core output.
REQ-027 SHALL make busy = (state==BUSY) and hold cur_sel stable throughout BUSY.
REQ-028 SHALL make N=1 degenerate correctly: SEL_W=1, g=0 always, ptr constant 0.

Reset
REQ-029 SHALL, on rst=1 at a clock edge in any state including mid-BUSY, set state=IDLE, ptr=0, cur_sel=0, rd_data=0, rd_reorder_tag=0, byte_len=0, rd_data_vld=0.
REQ-030 SHALL hold rdy=0, fwd_rd_en=0, fwd_done=0 and rdy_for_fwd_ack=0 while rst is asserted.

Structure
REQ-031 SHALL place the CLOG2 macro and the IDLE/BUSY state encodings in shared header fwd_arb_defs.vh, reused by the fwd_arb family.
REQ-032 SHALL implement grant selection in one combinational sub-module rr_pick (inputs req[N], ptr[SEL_W], mode; outputs idx[SEL_W], any).
REQ-033 SHALL build the return-path mux as an indexed part-select on cur_sel feeding the output registers, with no separate mux tree.

Verification
REQ-034 SHALL cover: N=4, RR, rdy_for_fwd=4'b1111 with ack held 1 and done pulsed after each grant -> ack pulses at bits 0,1,2,3,0 in order.
REQ-035 SHALL cover: ARB_MODE=0, rdy_for_fwd=4'b1010 repeated sessions -> every grant goes to index 1.
REQ-036 SHALL cover: session on core 2 with rd_en=1 and addr=8'h15 -> fwd_rd_en=4'b0100, fwd_addr=8'h15; core 2 data 64'hDEAD_BEEF with vld=1 -> rd_data=64'hDEAD_BEEF, rd_data_vld=1 one cycle later.
REQ-037 SHALL cover: done and rdy_for_fwd=4'b0001 in the same BUSY cycle -> fwd_done=4'b(sel); rdy=0 that cycle and rdy=1 the next.
REQ-038 SHALL cover: rst asserted mid-BUSY on core 3 -> next cycle busy=0, cur_sel=0, rd_data_vld=0; the following grant with all requests set goes to core 0.
REQ-039 SHALL cover: ack=1 while rdy_for_fwd=0 and done=1 in IDLE -> no ack pulse, fwd_done=0, state stays IDLE.

Source files
------------

// File: rtl/fwd_arb_rr_pkg.sv
// rtl/fwd_arb_rr_pkg.sv - shared state encodings and width helper for the fwd_arb family
package fwd_arb_rr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Selection index width; a single core still needs a 1-bit index.
  function automatic int clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fwd_arb_rr_pick.sv
// rtl/fwd_arb_rr_pick.sv - combinational grant picker (fixed priority or rotate from ptr)
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  int cand;

  // Scan N candidates starting at ptr (rotating) or at 0 (fixed); first hit wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int i = 0; i < N; i++) begin
      cand = mode ? ((int'(ptr) + i) % N) : i;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fwd_arb_rr.sv
// rtl/fwd_arb_rr.sv - forwarder-to-packetfilter-core session arbiter with registered return path
module fwd_arb_rr
  import fwd_arb_rr_pkg::*;
#(
  parameter int N                  = 4,
  parameter int PACKMEM_ADDR_WIDTH = 8,
  parameter int PACKMEM_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH         = 32,
  parameter int TAG_WIDTH          = 6,
  parameter int ARB_MODE           = 1,
  localparam int SEL_W             = clog2(N)
) (
  input  logic                            clk,
  input  logic                            rst,
  // forwarder side
  input  logic [PACKMEM_ADDR_WIDTH-1:0]   addr,
  input  logic                            rd_en,
  output logic [PACKMEM_DATA_WIDTH-1:0]   rd_data,
  output logic [TAG_WIDTH-1:0]            rd_reorder_tag,
  output logic                            rd_data_vld,
  output logic [PLEN_WIDTH-1:0]           byte_len,
  input  logic                            done,
  output logic                            rdy,
  input  logic                            ack,
  // core side
  output logic [PACKMEM_ADDR_WIDTH-1:0]   fwd_addr,
  output logic [N-1:0]                    fwd_rd_en,
  input  logic [N*PACKMEM_DATA_WIDTH-1:0] fwd_rd_data,
  input  logic [N*TAG_WIDTH-1:0]          fwd_rd_reorder_tag,
  input  logic [N-1:0]                    fwd_rd_data_vld,
  input  logic [N*PLEN_WIDTH-1:0]         fwd_byte_len,
  output logic [N-1:0]                    fwd_done,
  input  logic [N-1:0]                    rdy_for_fwd,
  output logic [N-1:0]                    rdy_for_fwd_ack,
  // status
  output logic                            busy,
  output logic [SEL_W-1:0]                cur_sel
);

  arb_state_e                  state_q, state_d;
  logic [SEL_W-1:0]            ptr_q, ptr_d;
  logic [SEL_W-1:0]            cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]            g;
  logic                        any_req;
  logic [PACKMEM_DATA_WIDTH-1:0] rd_data_q;
  logic [TAG_WIDTH-1:0]        rd_tag_q;
  logic [PLEN_WIDTH-1:0]       byte_len_q;
  logic                        rd_data_vld_q;
  logic                        busy_w;
  logic [N-1:0]                sel_oh;
  logic [N-1:0]                grant_oh;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req  (rdy_for_fwd),
    .ptr  (ptr_q),
    .mode (ARB_MODE != 0),
    .idx  (g),
    .any  (any_req)
  );

  assign busy_w   = (state_q == ST_BUSY);
  assign sel_oh   = N'(1) << cur_sel_q;
  assign grant_oh = N'(1) << g;
  assign rdy      = !rst && (state_q == ST_IDLE) && any_req;
  assign fwd_addr = addr;
  assign busy     = busy_w;
  assign cur_sel  = cur_sel_q;

  // Steering of rd_en/done to the locked core; silent outside a session or under reset.
  always_comb begin
    fwd_rd_en = '0;
    fwd_done  = '0;
    if (busy_w && !rst) begin
      fwd_rd_en = rd_en ? sel_oh : '0;
      fwd_done  = done  ? sel_oh : '0;
    end
  end

  // Session FSM: grant on handshake, release on done; pointer rotates past the winner.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    cur_sel_d       = cur_sel_q;
    rdy_for_fwd_ack = '0;
    case (state_q)
      ST_IDLE: begin
        if (rdy && ack) begin
          rdy_for_fwd_ack = grant_oh;
          cur_sel_d       = g;
          state_d         = ST_BUSY;
          if (ARB_MODE != 0) begin
            ptr_d = (g == SEL_W'(N - 1)) ? '0 : g + 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, selection and return-path registers; return fields taken straight from the locked core's slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      cur_sel_q     <= '0;
      rd_data_q     <= '0;
      rd_tag_q      <= '0;
      byte_len_q    <= '0;
      rd_data_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cur_sel_q     <= cur_sel_d;
      rd_data_q     <= fwd_rd_data[int'(cur_sel_q)*PACKMEM_DATA_WIDTH +: PACKMEM_DATA_WIDTH];
      rd_tag_q      <= fwd_rd_reorder_tag[int'(cur_sel_q)*TAG_WIDTH +: TAG_WIDTH];
      byte_len_q    <= fwd_byte_len[int'(cur_sel_q)*PLEN_WIDTH +: PLEN_WIDTH];
      rd_data_vld_q <= fwd_rd_data_vld[cur_sel_q] && busy_w;
    end
  end

  assign rd_data        = rd_data_q;
  assign rd_reorder_tag = rd_tag_q;
  assign byte_len       = byte_len_q;
  assign rd_data_vld    = rd_data_vld_q;

endmodule
